// File: rtl/odo_encrypt_sched.sv
// odo_encrypt_sched
//   Shares one odo_encrypt pipeline among N_REQ hash cores. A round-robin
//   arbiter grants one valid requester per cycle, registers its 640-bit block
//   into the pipeline and pushes the requester index into an in-order tag
//   FIFO. Pipeline results are popped against that FIFO and returned to the
//   owning requester as a one-cycle pulse. After reset the block waits
//   ENC_LAT+2 cycles so that stale blocks in the unresettable pipeline drain
//   out before new work is issued.
// Ports
//   clk, reset            clock (posedge) and asynchronous active-high reset
//   req_valid/req_data    per-requester block offers, data at [i*640 +: 640]
//   req_ready             one-hot grant
//   enc_in/enc_read       block and strobe to the odo_encrypt pipeline
//   enc_out/enc_write     result and strobe from the odo_encrypt pipeline
//   rsp_data/rsp_valid    returned block and one-hot owner pulse
//   busy                  draining after reset, or blocks in flight
//   err_spur              sticky: enc_write in RUN with nothing in flight
//   issued_cnt            accepted blocks since reset (wraps)
module odo_encrypt_sched #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 64,
  parameter int ENC_LAT   = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*640-1:0] req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [639:0]         enc_in,
  output logic                 enc_read,
  input  logic [639:0]         enc_out,
  input  logic                 enc_write,
  output logic [639:0]         rsp_data,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 busy,
  output logic                 err_spur,
  output logic [31:0]          issued_cnt
);

  localparam int PW = $clog2(N_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(ENC_LAT + 3);

  localparam logic [0:0] S_DRAIN = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [CW-1:0] DEPTH      = CW'(TAG_DEPTH);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(ENC_LAT + 2);

  logic [0:0]    state;
  logic [DW-1:0] drain_cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic          run;
  logic          accept;
  logic          pop;
  logic          spur;

  logic [PW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  assign run = (state == S_RUN);

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PW'((32'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Capacity uses the registered count only: a pop this cycle does not make
  // room for this cycle's push.
  always_comb begin
    req_ready = '0;
    if (run && found && (fifo_count < DEPTH))
      req_ready[winner] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);
  assign pop    = run && enc_write && (fifo_count != '0);
  assign spur   = run && enc_write && (fifo_count == '0);
  assign busy   = (state == S_DRAIN) || (fifo_count != '0);

  // DRAIN_INIT >= 2, so the count reaches 0 exactly as the state enters RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DRAIN;
      drain_cnt <= DRAIN_INIT;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt - 1'b1;
      if (drain_cnt == DW'(1))
        state <= S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      enc_read   <= 1'b0;
      enc_in     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      issued_cnt <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_spur   <= 1'b0;
    end else begin
      enc_read  <= accept;
      rsp_valid <= '0;
      if (accept) begin
        enc_in     <= req_data[32'(winner)*640 +: 640];
        rr_ptr     <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        wr_ptr     <= wr_ptr + 1'b1;
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (pop) begin
        rd_ptr                      <= rd_ptr + 1'b1;
        rsp_valid[tag_mem[rd_ptr]]  <= 1'b1;
        rsp_data                    <= enc_out;
      end
      if (accept && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !accept)
        fifo_count <= fifo_count - 1'b1;
      if (spur)
        err_spur <= 1'b1;
    end
  end

endmodule
